read_trig_seq: RTL and testbench

Multi-channel successor to the single-chip read/reset/trigger controller. It accepts trigger edges from N_CH readout chips plus a software trigger, and arbitrates them into one readout window of programmable length. It drives the chip read-clock enable and the AD9228 read enable, then enforces a programmable holdoff. It also counts accepted and dropped triggers. It sits between the IPIF register block (already clock-converted into `clk`) and the chip/ADC pad logic. Clock gating itself stays at the top level, using `read_clk_en`.

---
 rtl/read_trig_pkg.sv | 32 +++
 rtl/trig_edge_detect.sv | 58 +++++
 rtl/read_trig_seq.sv | 199 +++++++++++++++++++
 tb/tb_read_trig_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_trig_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : read_trig_pkg                                              |
// | Purpose  : Shared types and helpers for the read/trigger sequencer:   |
// |            FSM state encoding, software-source bit position and a     |
// |            saturating increment for the dropped-trigger counter.      |
// | Revision : 1.0 - initial multi-channel release                        |
// +-----------------------------------------------------------------------+
package read_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // The software trigger sits just above the chip bits in trig_src.
  function automatic int unsigned sw_src_bit(input int unsigned n_ch);
    return n_ch;
  endfunction

  // Saturating +1 on a value of 'width' bits (width must be below 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    if (value >= max_val) return max_val;
    return value + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_edge_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : trig_edge_detect                                           |
// | Purpose  : Optional N-stage synchronizer followed by a rising-edge    |
// |            detector producing one-cycle pulses.                       |
// | Ports    : clk, rst  - clock, synchronous active-high reset           |
// |            din      - raw inputs (async when SYNC_STAGES > 0)         |
// |            rise     - one-cycle rising-edge pulses                    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module trig_edge_detect #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0]     sig;
  logic [WIDTH-1:0]     prev_q;
  logic [SYNC_STAGES:0] arm_q;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          // Shift in the new sample; the oldest stage falls off the top.
          sync_q <= (SYNC_STAGES*WIDTH)'({sync_q, din});
        end
      end
      assign sig = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign sig = din;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      prev_q <= sig;
      arm_q  <= (SYNC_STAGES+1)'({arm_q, 1'b1});
    end
  end

  // History is cleared by reset, so an input already high at release would
  // look like an edge. Edges are held off until the pipeline and the history
  // register both carry real samples (SYNC_STAGES+1 cycles after reset).
  assign rise = arm_q[SYNC_STAGES] ? (sig & ~prev_q) : '0;

endmodule
`default_nettype wire

// File: rtl/read_trig_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : read_trig_seq                                              |
// | Purpose  : Arbitrates N_CH chip triggers plus a software trigger into |
// |            one readout window of programmable length, followed by a   |
// |            programmable holdoff. Counts accepted and dropped triggers.|
// | Ports    : clk, rst          - clock, synchronous active-high reset   |
// |            trig_from_chip    - async chip triggers (rising edge)      |
// |            trig_mask         - channel enable / read selection        |
// |            software_trig     - clk-domain software trigger level      |
// |            num_data, holdoff - window length, dead time after window  |
// |            read_clk_en, AD9228_read_en - window enables               |
// |            read_ch, trig_src - read channels, last trigger sources    |
// |            busy              - READ or HOLDOFF                        |
// |            trigger_counter, dropped_counter - accepted / dropped      |
// |            trig_timestamp    - timestamp of last accepted trigger     |
// | Config   : READ_TRIG_TIMESTAMP_EN enables the free-running timestamp; |
// |            otherwise trig_timestamp is tied to zero.                  |
// | Revision : 1.0 - initial multi-channel release                        |
// +-----------------------------------------------------------------------+
module read_trig_seq
  import read_trig_pkg::*;
#(
  parameter int N_CH                   = 4,
  parameter int TRIGGER_COUNTER_LENGTH = 16,
  parameter int MAX_NUM_DATA           = 4096,
  parameter int HOLDOFF_WIDTH          = 16,
  parameter int TS_WIDTH               = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CH-1:0]                   trig_from_chip,
  input  logic [N_CH-1:0]                   trig_mask,
  input  logic                              software_trig,
  input  logic [$clog2(MAX_NUM_DATA):0]     num_data,
  input  logic [HOLDOFF_WIDTH-1:0]          holdoff,
  output logic                              read_clk_en,
  output logic                              AD9228_read_en,
  output logic [N_CH-1:0]                   read_ch,
  output logic [N_CH:0]                     trig_src,
  output logic                              busy,
  output logic [TRIGGER_COUNTER_LENGTH-1:0] trigger_counter,
  output logic [TRIGGER_COUNTER_LENGTH-1:0] dropped_counter,
  output logic [TS_WIDTH-1:0]               trig_timestamp
);

  localparam int ND_W       = $clog2(MAX_NUM_DATA) + 1;
  localparam int SW_SRC_BIT = sw_src_bit(N_CH);

  state_t state_q, state_d;

  logic [N_CH-1:0]                   chip_edge;
  logic                              sw_edge;
  logic [N_CH-1:0]                   qual_chip;
  logic                              any_trig;
  logic [N_CH:0]                     src_vec;
  logic [ND_W-1:0]                   len_clamped;
  logic [ND_W-1:0]                   len_q;
  logic [HOLDOFF_WIDTH-1:0]          hold_q;
  logic [N_CH-1:0]                   read_ch_q;
  logic [N_CH:0]                     trig_src_q;
  logic [TRIGGER_COUNTER_LENGTH-1:0] trig_cnt_q;
  logic [TRIGGER_COUNTER_LENGTH-1:0] drop_cnt_q;
  logic                              accept;
  logic                              drop;
  logic                              load_hold;

  trig_edge_detect #(
    .WIDTH       (N_CH),
    .SYNC_STAGES (2)
  ) u_chip_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (trig_from_chip),
    .rise (chip_edge)
  );

  trig_edge_detect #(
    .WIDTH       (1),
    .SYNC_STAGES (0)
  ) u_sw_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (software_trig),
    .rise (sw_edge)
  );

  assign qual_chip = chip_edge & trig_mask;
  assign any_trig  = sw_edge | (|qual_chip);

  always_comb begin
    src_vec                = '0;
    src_vec[N_CH-1:0]      = qual_chip;
    src_vec[SW_SRC_BIT]    = sw_edge;
  end

  // Window length: 0 means one cycle, anything above the maximum is clipped.
  always_comb begin
    if (num_data == '0) begin
      len_clamped = ND_W'(1);
    end else if (num_data > ND_W'(MAX_NUM_DATA)) begin
      len_clamped = ND_W'(MAX_NUM_DATA);
    end else begin
      len_clamped = num_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    drop      = 1'b0;
    load_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_trig) begin
          accept  = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        drop = any_trig;
        // len_q holds the cycles left including the current one.
        if (len_q <= ND_W'(1)) begin
          load_hold = 1'b1;
          state_d   = (holdoff == '0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        drop = any_trig;
        if (hold_q <= HOLDOFF_WIDTH'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      hold_q     <= '0;
      read_ch_q  <= '0;
      trig_src_q <= '0;
      trig_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept) begin
        len_q      <= len_clamped;
        read_ch_q  <= trig_mask;
        trig_src_q <= src_vec;
        trig_cnt_q <= trig_cnt_q + TRIGGER_COUNTER_LENGTH'(1);
      end else if (state_q == READ) begin
        len_q <= len_q - ND_W'(1);
      end

      if (load_hold) begin
        hold_q <= holdoff;
      end else if (state_q == HOLDOFF) begin
        hold_q <= hold_q - HOLDOFF_WIDTH'(1);
      end

      if (drop) begin
        drop_cnt_q <= TRIGGER_COUNTER_LENGTH'(sat_inc(64'(drop_cnt_q), TRIGGER_COUNTER_LENGTH));
      end
    end
  end

`ifdef READ_TRIG_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;
  logic [TS_WIDTH-1:0] ts_latch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      ts_latch_q <= '0;
    end else begin
      ts_q <= ts_q + TS_WIDTH'(1);
      if (accept) ts_latch_q <= ts_q;
    end
  end

  assign trig_timestamp = ts_latch_q;
`else
  assign trig_timestamp = {TS_WIDTH{1'b0}};
`endif

  assign read_clk_en     = (state_q == READ);
  assign AD9228_read_en  = (state_q == READ);
  assign busy            = (state_q != IDLE);
  assign read_ch         = read_ch_q;
  assign trig_src        = trig_src_q;
  assign trigger_counter = trig_cnt_q;
  assign dropped_counter = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_read_trig_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_read_trig_seq                                           |
// | Purpose  : Directed self-checking bench for read_trig_seq. A second,  |
// |            narrow-counter instance covers counter wrap/saturation.    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_read_trig_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trig_from_chip;
  logic [3:0]  trig_mask;
  logic        software_trig;
  logic [12:0] num_data;
  logic [15:0] holdoff;
  logic        read_clk_en;
  logic        AD9228_read_en;
  logic [3:0]  read_ch;
  logic [4:0]  trig_src;
  logic        busy;
  logic [15:0] trigger_counter;
  logic [15:0] dropped_counter;
  logic [31:0] trig_timestamp;

  // narrow instance
  logic        w_sw;
  logic [4:0]  w_num;
  logic [15:0] w_hold;
  logic        w_rce, w_ae, w_busy;
  logic [0:0]  w_rch;
  logic [1:0]  w_src;
  logic [3:0]  w_tc, w_dc;
  logic [31:0] w_ts;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  read_trig_seq dut (
    .clk             (clk),
    .rst             (rst),
    .trig_from_chip  (trig_from_chip),
    .trig_mask       (trig_mask),
    .software_trig   (software_trig),
    .num_data        (num_data),
    .holdoff         (holdoff),
    .read_clk_en     (read_clk_en),
    .AD9228_read_en  (AD9228_read_en),
    .read_ch         (read_ch),
    .trig_src        (trig_src),
    .busy            (busy),
    .trigger_counter (trigger_counter),
    .dropped_counter (dropped_counter),
    .trig_timestamp  (trig_timestamp)
  );

  read_trig_seq #(
    .N_CH                   (1),
    .TRIGGER_COUNTER_LENGTH (4),
    .MAX_NUM_DATA           (16)
  ) dut_w (
    .clk             (clk),
    .rst             (rst),
    .trig_from_chip  (1'b0),
    .trig_mask       (1'b0),
    .software_trig   (w_sw),
    .num_data        (w_num),
    .holdoff         (w_hold),
    .read_clk_en     (w_rce),
    .AD9228_read_en  (w_ae),
    .read_ch         (w_rch),
    .trig_src        (w_src),
    .busy            (w_busy),
    .trigger_counter (w_tc),
    .dropped_counter (w_dc),
    .trig_timestamp  (w_ts)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ticks until read_clk_en is seen high; returns -1 if it never rises.
  task automatic wait_start(output int dly);
    dly = 0;
    do begin
      tick();
      dly++;
    end while (!read_clk_en && dly < 20);
    if (!read_clk_en) dly = -1;
  endtask

  // Counts cycles read_clk_en stays high, starting with the current one.
  task automatic count_len(output int n);
    n = 0;
    while (read_clk_en && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic run_window(output int dly, output int n);
    wait_start(dly);
    n = 0;
    if (dly > 0) count_len(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dly, n, h;
    bit saw;
    logic [31:0] exp_ts1, exp_ts2;
`ifdef READ_TRIG_TIMESTAMP_EN
    exp_ts1 = 32'd100;
    exp_ts2 = 32'd350;
`else
    exp_ts1 = 32'd0;
    exp_ts2 = 32'd0;
`endif

    rst = 1'b1; trig_from_chip = '0; trig_mask = '0; software_trig = 1'b0;
    num_data = 13'd8; holdoff = '0;
    w_sw = 1'b0; w_num = 5'd1; w_hold = '0;
    tick(3);
    check_eq("rst_rce",  read_clk_en, 0);
    check_eq("rst_ae",   AD9228_read_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tc",   trigger_counter, 0);
    check_eq("rst_dc",   dropped_counter, 0);
    check_eq("rst_src",  trig_src, 0);
    check_eq("rst_rch",  read_ch, 0);
    check_eq("rst_ts",   trig_timestamp, 0);
    rst = 1'b0;
    tick(4);

    // Software trigger, 8-cycle window
    software_trig = 1'b1;
    wait_start(dly);
    check_eq("sw_dly",  dly, 1);
    check_eq("sw_ae",   AD9228_read_en, 1);
    check_eq("sw_busy", busy, 1);
    check_eq("sw_tc",   trigger_counter, 1);
    check_eq("sw_src",  trig_src, 5'b10000);
    count_len(n);
    check_eq("sw_len",  n, 8);
    check_eq("sw_busy_end", busy, 0);
    software_trig = 1'b0;
    tick(2);

    // Masked chip 2, 1280-cycle window
    trig_mask = 4'b0100; num_data = 13'd1280; trig_from_chip = 4'b0100;
    run_window(dly, n);
    check_eq("ch2_dly", dly, 3);
    check_eq("ch2_len", n, 1280);
    check_eq("ch2_rch", read_ch, 4'b0100);
    check_eq("ch2_src", trig_src, 5'b00100);
    check_eq("ch2_tc",  trigger_counter, 2);
    trig_from_chip = 4'b0000;
    tick(4);
    trig_from_chip = 4'b0001;
    run_window(dly, n);
    check_eq("ch0_masked", dly, -1);
    check_eq("ch0_tc", trigger_counter, 2);
    trig_from_chip = 4'b0000;
    tick(4);

    // Drops during READ and HOLDOFF; live num_data/holdoff changes
    trig_mask = 4'b0101; num_data = 13'd10; holdoff = 16'd20; trig_from_chip = 4'b0001;
    wait_start(dly);
    check_eq("drop_dly", dly, 3);
    check_eq("drop_src", trig_src, 5'b00001);
    num_data = 13'd3;
    trig_from_chip = 4'b0000;
    n = 0;
    while (read_clk_en && n < 100) begin
      n++;
      if (n == 3) trig_from_chip = 4'b0001;
      tick();
    end
    check_eq("drop_len", n, 10);
    check_eq("drop_hold_busy", busy, 1);
    h = 0;
    while (busy && h < 100) begin
      h++;
      if (h == 1) holdoff = 16'd1;
      if (h == 2) trig_from_chip = 4'b0000;
      if (h == 4) trig_from_chip = 4'b0001;
      tick();
    end
    check_eq("drop_hold_len", h, 20);
    check_eq("drop_dc", dropped_counter, 2);
    check_eq("drop_tc", trigger_counter, 3);
    trig_from_chip = 4'b0000; holdoff = '0;
    tick(4);

    // Simultaneous chip 2 and software edges
    trig_mask = 4'b0100; num_data = 13'd5; trig_from_chip = 4'b0100;
    tick(2);
    software_trig = 1'b1;
    run_window(dly, n);
    check_eq("sim_dly", dly, 1);
    check_eq("sim_len", n, 5);
    check_eq("sim_tc",  trigger_counter, 4);
    check_eq("sim_src", trig_src, 5'b10100);
    software_trig = 1'b0; trig_from_chip = 4'b0000;
    tick(4);

    // Window length boundaries
    num_data = 13'd0; software_trig = 1'b1;
    run_window(dly, n);
    check_eq("len0", n, 1);
    software_trig = 1'b0; tick(2);
    num_data = 13'd4101; software_trig = 1'b1;
    run_window(dly, n);
    check_eq("lenmax", n, 4096);
    check_eq("lenmax_tc", trigger_counter, 6);
    check_eq("lenmax_dc", dropped_counter, 2);
    software_trig = 1'b0; tick(2);

    // Back-to-back with zero holdoff
    num_data = 13'd2;
    software_trig = 1'b1; tick();
    software_trig = 1'b0; tick();
    tick();
    check_eq("b2b_idle", read_clk_en, 0);
    software_trig = 1'b1; tick();
    check_eq("b2b_restart", read_clk_en, 1);
    check_eq("b2b_tc", trigger_counter, 8);
    software_trig = 1'b0;
    tick(4);

    // Reset mid-window, trigger held high across reset
    num_data = 13'd100; trig_mask = 4'b0001; trig_from_chip = 4'b0001;
    wait_start(dly);
    check_eq("rmw_dly", dly, 3);
    tick(5);
    rst = 1'b1; tick();
    check_eq("rmw_rce",  read_clk_en, 0);
    check_eq("rmw_ae",   AD9228_read_en, 0);
    check_eq("rmw_busy", busy, 0);
    check_eq("rmw_tc",   trigger_counter, 0);
    check_eq("rmw_rch",  read_ch, 0);
    check_eq("rmw_src",  trig_src, 0);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (read_clk_en) saw = 1'b1;
    end
    check_eq("rmw_held_no_window", saw, 0);
    trig_from_chip = 4'b0000; tick(3);
    num_data = 13'd4; trig_from_chip = 4'b0001;
    run_window(dly, n);
    check_eq("rmw_retrig_len", n, 4);
    check_eq("rmw_retrig_tc", trigger_counter, 1);
    trig_from_chip = 4'b0000;

    // Timestamp of accepted triggers
    while (cyc < 100) tick();
    software_trig = 1'b1;
    run_window(dly, n);
    check_eq("ts_100", trig_timestamp, exp_ts1);
    software_trig = 1'b0;
    while (cyc < 350) tick();
    software_trig = 1'b1;
    run_window(dly, n);
    check_eq("ts_350", trig_timestamp, exp_ts2);
    check_eq("ts_tc", trigger_counter, 3);
    software_trig = 1'b0;
    tick(2);

    // Narrow instance: accepted counter wraps
    w_num = 5'd1; w_hold = '0;
    for (int i = 1; i <= 16; i++) begin
      w_sw = 1'b1; tick();
      w_sw = 1'b0; tick();
      if (i == 15) check_eq("wrap_15", w_tc, 4'hF);
    end
    check_eq("wrap_0", w_tc, 4'h0);

    // Narrow instance: dropped counter saturates
    w_num = 5'd16; w_hold = 16'd40;
    w_sw = 1'b1; tick();
    check_eq("sat_busy", w_busy, 1);
    check_eq("sat_tc", w_tc, 1);
    for (int p = 1; p <= 20; p++) begin
      w_sw = 1'b0; tick();
      w_sw = 1'b1; tick();
      if (p == 14) check_eq("sat_14", w_dc, 4'd14);
      if (p == 15) check_eq("sat_15", w_dc, 4'hF);
    end
    check_eq("sat_20", w_dc, 4'hF);
    check_eq("sat_tc_hold", w_tc, 1);
    w_sw = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
